// File: rtl/risc_control_unit_if.sv
// ---------------------------------------------------------------------------
// risc_control_unit_if
// Bundle between the instruction-sequencing control unit and the RISC SPM
// datapath.
//   master : control-unit side. Reads instruction/zero and drives every
//            strobe and select.
//   slave  : datapath side. Drives instruction (IR contents) and zero
//            (Reg_Z), and reads the strobes and selects.
// Signals:
//   instruction [WORD_W]  IR contents
//   zero                  registered ALU zero flag (Reg_Z)
//   alu_sel     [4]       ALU opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT
//   sel_bus_1   [3]       Bus_1 source: 0..3 = R0..R3, 4 = PC
//   sel_bus_2   [2]       Bus_2 source: 0 = ALU_out, 1 = Bus_1, 2 = memory
//   load_r      [4]       one-hot load strobe for R0..R3
//   load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write
//   halted                high while the sequencer is halted
// ---------------------------------------------------------------------------
interface risc_control_unit_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] instruction;
  logic              zero;
  logic [3:0]        alu_sel;
  logic [2:0]        sel_bus_1;
  logic [1:0]        sel_bus_2;
  logic [3:0]        load_r;
  logic              load_pc;
  logic              inc_pc;
  logic              load_ir;
  logic              load_add_r;
  logic              load_reg_y;
  logic              load_reg_z;
  logic              write;
  logic              halted;

  modport master (
    input  instruction, zero,
    output alu_sel, sel_bus_1, sel_bus_2, load_r, load_pc, inc_pc,
           load_ir, load_add_r, load_reg_y, load_reg_z, write, halted
  );

  modport slave (
    output instruction, zero,
    input  alu_sel, sel_bus_1, sel_bus_2, load_r, load_pc, inc_pc,
           load_ir, load_add_r, load_reg_y, load_reg_z, write, halted
  );
endinterface

// File: rtl/risc_control_unit.sv
// ---------------------------------------------------------------------------
// risc_control_unit
// Instruction-sequencing FSM for the 8-bit RISC SPM datapath. Fetches,
// decodes and executes one instruction at a time. All outputs are
// combinational from the state register and the current IR contents.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high (state -> S_IDLE, strobes drop
//         immediately because outputs decode from the state)
//   bus   risc_control_unit_if.master: instruction/zero in, strobes out
// Parameters:
//   WORD_W           IR width, opcode in the top nibble (>= 8)
//   HALT_ON_ILLEGAL  1: opcodes 9..15 halt the sequencer, 0: act as NOP
// ---------------------------------------------------------------------------
module risc_control_unit #(
  parameter int WORD_W          = 8,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  risc_control_unit_if.master bus
);

  // State encoding
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_FET1 = 4'd1;
  localparam logic [3:0] S_FET2 = 4'd2;
  localparam logic [3:0] S_DEC  = 4'd3;
  localparam logic [3:0] S_EX1  = 4'd4;
  localparam logic [3:0] S_RD1  = 4'd5;
  localparam logic [3:0] S_RD2  = 4'd6;
  localparam logic [3:0] S_WR1  = 4'd7;
  localparam logic [3:0] S_WR2  = 4'd8;
  localparam logic [3:0] S_BR1  = 4'd9;
  localparam logic [3:0] S_BR2  = 4'd10;
  localparam logic [3:0] S_HALT = 4'd11;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  // Bus select codes
  localparam logic [2:0] B1_PC  = 3'd4;
  localparam logic [1:0] B2_ALU = 2'd0;
  localparam logic [1:0] B2_B1  = 2'd1;
  localparam logic [1:0] B2_MEM = 2'd2;

  localparam logic [3:0] ALU_NOT = 4'd4;

  logic [3:0] state_q, state_d;

  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic [3:0] dest_oh;

  logic [3:0] alu_sel;
  logic [2:0] sel_bus_1;
  logic [1:0] sel_bus_2;
  logic [3:0] load_r;
  logic       load_pc;
  logic       inc_pc;
  logic       load_ir;
  logic       load_add_r;
  logic       load_reg_y;
  logic       load_reg_z;
  logic       write;
  logic       halted;

  assign opcode  = bus.instruction[WORD_W-1 -: 4];
  assign src     = bus.instruction[3:2];
  assign dest    = bus.instruction[1:0];
  assign dest_oh = 4'b0001 << dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_sel    = 4'd0;
    sel_bus_1  = 3'd0;
    sel_bus_2  = B2_ALU;
    load_r     = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write      = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FET1;
      end

      // Address register <= PC
      S_FET1: begin
        sel_bus_1  = B1_PC;
        sel_bus_2  = B2_B1;
        load_add_r = 1'b1;
        state_d    = S_FET2;
      end

      // IR <= mem[Add_R], PC advances past the instruction word
      S_FET2: begin
        sel_bus_2 = B2_MEM;
        load_ir   = 1'b1;
        inc_pc    = 1'b1;
        state_d   = S_DEC;
      end

      S_DEC: begin
        case (opcode)
          OP_NOP: begin
            state_d = S_FET1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            // First operand parks in Reg_Y; second is applied in S_EX1
            sel_bus_1  = {1'b0, src};
            sel_bus_2  = B2_B1;
            load_reg_y = 1'b1;
            state_d    = S_EX1;
          end
          OP_NOT: begin
            // Unary op completes in one cycle straight from Bus_1
            sel_bus_1  = {1'b0, src};
            sel_bus_2  = B2_ALU;
            alu_sel    = ALU_NOT;
            load_r     = dest_oh;
            load_reg_z = 1'b1;
            state_d    = S_FET1;
          end
          OP_RD, OP_WR, OP_BR: begin
            // Point Add_R at the operand/address word following the opcode
            sel_bus_1  = B1_PC;
            sel_bus_2  = B2_B1;
            load_add_r = 1'b1;
            state_d    = (opcode == OP_RD) ? S_RD1 :
                         (opcode == OP_WR) ? S_WR1 : S_BR1;
          end
          OP_BRZ: begin
            if (bus.zero) begin
              sel_bus_1  = B1_PC;
              sel_bus_2  = B2_B1;
              load_add_r = 1'b1;
              state_d    = S_BR1;
            end else begin
              // Not taken: step PC over the unused address word
              inc_pc  = 1'b1;
              state_d = S_FET1;
            end
          end
          default: begin
            state_d = HALT_ON_ILLEGAL ? S_HALT : S_FET1;
          end
        endcase
      end

      // Second operand from dest; the ALU opcode equals the instruction opcode
      S_EX1: begin
        sel_bus_1  = {1'b0, dest};
        sel_bus_2  = B2_ALU;
        alu_sel    = opcode;
        load_r     = dest_oh;
        load_reg_z = 1'b1;
        state_d    = S_FET1;
      end

      // Add_R <= address word, PC past it
      S_RD1: begin
        sel_bus_2  = B2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = S_RD2;
      end

      S_RD2: begin
        sel_bus_2 = B2_MEM;
        load_r    = dest_oh;
        state_d   = S_FET1;
      end

      S_WR1: begin
        sel_bus_2  = B2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = S_WR2;
      end

      S_WR2: begin
        sel_bus_1 = {1'b0, src};
        write     = 1'b1;
        state_d   = S_FET1;
      end

      // Add_R <= address word; no inc_pc since PC is reloaded next cycle
      S_BR1: begin
        sel_bus_2  = B2_MEM;
        load_add_r = 1'b1;
        state_d    = S_BR2;
      end

      S_BR2: begin
        sel_bus_2 = B2_MEM;
        load_pc   = 1'b1;
        state_d   = S_FET1;
      end

      // Sticky until reset
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.alu_sel    = alu_sel;
  assign bus.sel_bus_1  = sel_bus_1;
  assign bus.sel_bus_2  = sel_bus_2;
  assign bus.load_r     = load_r;
  assign bus.load_pc    = load_pc;
  assign bus.inc_pc     = inc_pc;
  assign bus.load_ir    = load_ir;
  assign bus.load_add_r = load_add_r;
  assign bus.load_reg_y = load_reg_y;
  assign bus.load_reg_z = load_reg_z;
  assign bus.write      = write;
  assign bus.halted     = halted;

endmodule

// File: tb/tb_risc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_risc_control_unit
// Two control units share clk/rst and see identical instruction/zero
// streams: dut_h halts on illegal opcodes, dut_n treats them as NOP. A
// per-instruction micro-op schedule model predicts every output cycle.
// ---------------------------------------------------------------------------
module tb_risc_control_unit;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic [3:0] load_r;
    logic [7:0] flags;  // load_pc inc_pc load_ir load_add_r load_reg_y load_reg_z write halted
  } ctl_t;

  localparam logic [7:0] F_NONE = 8'h00;
  localparam logic [7:0] F_PC   = 8'h80;
  localparam logic [7:0] F_INC  = 8'h40;
  localparam logic [7:0] F_IR   = 8'h20;
  localparam logic [7:0] F_AR   = 8'h10;
  localparam logic [7:0] F_RY   = 8'h08;
  localparam logic [7:0] F_RZ   = 8'h04;
  localparam logic [7:0] F_WR   = 8'h02;
  localparam logic [7:0] F_HALT = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  risc_control_unit_if #(.WORD_W(8)) ifc_h ();
  risc_control_unit_if #(.WORD_W(8)) ifc_n ();

  risc_control_unit #(.WORD_W(8), .HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk (clk),
    .rst (rst),
    .bus (ifc_h.master)
  );

  risc_control_unit #(.WORD_W(8), .HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (ifc_n.master)
  );

  ctl_t obs_h, obs_n;
  assign obs_h = {ifc_h.alu_sel, ifc_h.sel_bus_1, ifc_h.sel_bus_2, ifc_h.load_r,
                  ifc_h.load_pc, ifc_h.inc_pc, ifc_h.load_ir, ifc_h.load_add_r,
                  ifc_h.load_reg_y, ifc_h.load_reg_z, ifc_h.write, ifc_h.halted};
  assign obs_n = {ifc_n.alu_sel, ifc_n.sel_bus_1, ifc_n.sel_bus_2, ifc_n.load_r,
                  ifc_n.load_pc, ifc_n.inc_pc, ifc_n.load_ir, ifc_n.load_add_r,
                  ifc_n.load_reg_y, ifc_n.load_reg_z, ifc_n.write, ifc_n.halted};

  ctl_t q_h[$];
  ctl_t q_n[$];
  bit   halted_h;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic ctl_t v(input logic [3:0] alu, input logic [2:0] s1,
                             input logic [1:0] s2, input logic [3:0] lr,
                             input logic [7:0] fl);
    ctl_t c;
    c.alu_sel   = alu;
    c.sel_bus_1 = s1;
    c.sel_bus_2 = s2;
    c.load_r    = lr;
    c.flags     = fl;
    return c;
  endfunction

  task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_excl(input string tag, input ctl_t o);
    logic [1:0] ok;
    n_cmp++;
    ok = {($countones(o.load_r) <= 1), !(o.flags[7] && o.flags[6])};
    assert (ok === 2'b11) else begin
      n_err++;
      $error("FAIL %s_excl: observed load_r=%b pc/inc=%b%b expected onehot0 and not both",
             tag, o.load_r, o.flags[7], o.flags[6]);
    end
  endtask

  // Expected per-cycle outputs from S_FET1 entry until the next S_FET1 entry.
  task automatic push_instr(input logic [7:0] ins, input logic z);
    logic [3:0] op;
    logic [2:0] s, d;
    logic [3:0] oh;
    ctl_t       seq[$];
    ctl_t       to_addr;
    bit         illegal;
    op      = ins[7:4];
    s       = {1'b0, ins[3:2]};
    d       = {1'b0, ins[1:0]};
    oh      = 4'b0001 << ins[1:0];
    illegal = 1'b0;
    to_addr = v(4'd0, 3'd4, 2'd1, 4'd0, F_AR);
    seq.push_back(to_addr);
    seq.push_back(v(4'd0, 3'd0, 2'd2, 4'd0, F_IR | F_INC));
    case (op)
      4'd0: seq.push_back(v(4'd0, 3'd0, 2'd0, 4'd0, F_NONE));
      4'd1, 4'd2, 4'd3: begin
        seq.push_back(v(4'd0, s, 2'd1, 4'd0, F_RY));
        seq.push_back(v(op, d, 2'd0, oh, F_RZ));
      end
      4'd4: seq.push_back(v(4'd4, s, 2'd0, oh, F_RZ));
      4'd5: begin
        seq.push_back(to_addr);
        seq.push_back(v(4'd0, 3'd0, 2'd2, 4'd0, F_AR | F_INC));
        seq.push_back(v(4'd0, 3'd0, 2'd2, oh, F_NONE));
      end
      4'd6: begin
        seq.push_back(to_addr);
        seq.push_back(v(4'd0, 3'd0, 2'd2, 4'd0, F_AR | F_INC));
        seq.push_back(v(4'd0, s, 2'd0, 4'd0, F_WR));
      end
      4'd7, 4'd8: begin
        if (op == 4'd8 && !z) begin
          seq.push_back(v(4'd0, 3'd0, 2'd0, 4'd0, F_INC));
        end else begin
          seq.push_back(to_addr);
          seq.push_back(v(4'd0, 3'd0, 2'd2, 4'd0, F_AR));
          seq.push_back(v(4'd0, 3'd0, 2'd2, 4'd0, F_PC));
        end
      end
      default: begin
        seq.push_back(v(4'd0, 3'd0, 2'd0, 4'd0, F_NONE));
        illegal = 1'b1;
      end
    endcase
    foreach (seq[k]) begin
      q_n.push_back(seq[k]);
      q_h.push_back(halted_h ? v(4'd0, 3'd0, 2'd0, 4'd0, F_HALT) : seq[k]);
    end
    if (illegal) halted_h = 1'b1;
  endtask

  task automatic drive(input logic [7:0] ins, input logic z);
    ifc_h.instruction = ins;
    ifc_n.instruction = ins;
    ifc_h.zero        = z;
    ifc_n.zero        = z;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input string tag);
    ctl_t e_h, e_n;
    @(negedge clk);
    e_h = q_h.pop_front();
    e_n = q_n.pop_front();
    check({tag, "/halt"}, obs_h, e_h);
    check({tag, "/nop"},  obs_n, e_n);
    check_excl(tag, obs_n);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [7:0] ins, input logic z);
    drive(ins, z);
    push_instr(ins, z);
    while (q_n.size() != 0) step(tag);
  endtask

  // Called at posedge+1; leaves both units in S_FET1 at posedge+1.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "/rst_h"}, obs_h, 21'd0);
    check({tag, "/rst_n"}, obs_n, 21'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "/rst_hold"}, obs_h, 21'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_h.delete();
    q_n.delete();
    halted_h = 1'b0;
    q_h.push_back(v(4'd0, 3'd0, 2'd0, 4'd0, F_NONE));
    q_n.push_back(v(4'd0, 3'd0, 2'd0, 4'd0, F_NONE));
    step({tag, "/idle"});
  endtask

  initial begin
    logic [7:0] ins;
    logic [3:0] op;
    logic [3:0] regs;
    logic       z;

    halted_h = 1'b0;
    drive(8'h00, 1'b0);
    @(posedge clk);
    #1;
    do_reset("init");

    // Directed instructions
    run_instr("add_r1_r2",  8'h16, 1'b0);
    run_instr("not_r3_r2",  8'h4E, 1'b1);
    run_instr("brz_nt",     8'h80, 1'b0);
    run_instr("brz_tk",     8'h80, 1'b1);
    run_instr("rd_r3",      8'h5B, 1'b0);
    run_instr("wr_r1",      8'h64, 1'b0);
    run_instr("add_r1_r1",  8'h15, 1'b0);
    run_instr("sub_r0_r3",  8'h23, 1'b1);
    run_instr("and_r2_r0",  8'h38, 1'b0);
    run_instr("br",         8'h70, 1'b0);
    run_instr("nop",        8'h00, 1'b1);

    // Illegal opcode: halting unit freezes, the other carries on as NOP
    run_instr("illegal_f0", 8'hF0, 1'b0);
    for (int i = 0; i < 7; i++) run_instr("post_halt", 8'h16, 1'b1);
    check("halt_sticky", {20'd0, obs_h.flags[0]}, 21'd1);
    do_reset("halt_exit");

    // Reset while S_WR2 drives write
    drive(8'h64, 1'b0);
    push_instr(8'h64, 1'b0);
    repeat (4) step("wr_pre");
    check("wr2_write", {20'd0, obs_n.flags[1]}, 21'd1);
    rst = 1'b1;
    #1;
    check("wr2_rst_write", {20'd0, obs_n.flags[1] | obs_h.flags[1]}, 21'd0);
    do_reset("wr2_rst");

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
      else                           op = 4'($urandom_range(0, 8));
      regs = 4'($urandom_range(0, 15));
      z    = 1'($urandom_range(0, 1));
      ins  = {op, regs};
      run_instr("rand", ins, z);
      if ($urandom_range(0, 39) == 0) do_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
